// File: rtl/uniciclo_seq_pkg.sv
// Shared types and constants for the uniciclo phase sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package uniciclo_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PH_PC,
        PH_INST,
        PH_DATA,
        PH_REG,
        EVAL,
        DUMP,
        DONE
    } seq_state_t;

    localparam logic [1:0] HALT_NONE   = 2'd0;
    localparam logic [1:0] HALT_EMPTY  = 2'd1;
    localparam logic [1:0] HALT_CYCLES = 2'd2;

    localparam int NREGS = 32;

endpackage

// File: rtl/uniciclo_phase_sequencer_phase_timer.sv
// Phase down-counter: loaded with (phase length - 1), flags the last tick of the phase.
// Latency: load takes effect on the next tick; last is combinational from the count.
// Backpressure: none.
// Ports: clock, reset (sync, active-high), load, load_val, last.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/uniciclo_phase_sequencer.sv
// Phase-strobe driver for the multi-clock single-cycle MIPS core, with halt detection and optional register dump.
// Latency: all outputs registered; one instruction period = T_PC+T_INST+T_DATA+T_REG+1 ticks.
// Backpressure: dump words are held stable while dump_valid && !dump_ready; at most one word per 2 ticks.
// Ports: clock/reset/start control; instruction from the core; pc/inst/data/muu/reg phase strobes;
//        running/done/halt_reason/cycle_count status; dump_addr/dump_data bank read; dump_valid/ready/index/value stream.
// Build option: define REG_DUMP_EN to build the register-bank dump; otherwise halt goes straight to DONE.
module uniciclo_phase_sequencer
    import uniciclo_seq_pkg::*;
#(
    parameter int T_PC        = 1,
    parameter int T_INST      = 5,
    parameter int T_DATA      = 5,
    parameter int T_REG       = 1,
    parameter int NUM_CYCLES  = 100,
    parameter int EMPTY_LIMIT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] instruction,
    output logic        pc_clock,
    output logic        inst_clock,
    output logic        data_clock,
    output logic        muu_clock,
    output logic        reg_clock,
    output logic        running,
    output logic        done,
    output logic [1:0]  halt_reason,
    output logic [15:0] cycle_count,
    output logic [4:0]  dump_addr,
    input  logic [31:0] dump_data,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_index,
    output logic [31:0] dump_value
);

`ifdef REG_DUMP_EN
    localparam seq_state_t HALT_DEST = DUMP;
`else
    localparam seq_state_t HALT_DEST = DONE;
`endif

    seq_state_t  state, state_n;
    logic        tmr_load, tmr_last;
    logic [7:0]  tmr_val;
    logic [15:0] cycle_n;
    logic [3:0]  empty_cnt, empty_n;
    logic [1:0]  halt_n;
    logic        inst_zero, inst_zero_n;

`ifdef REG_DUMP_EN
    logic [4:0]  dump_idx, dump_idx_n;
    logic        dump_valid_n;
    logic [4:0]  dump_index_n;
    logic [31:0] dump_value_n;
`endif

    phase_timer #(.W(8)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .last     (tmr_last)
    );

    always_comb begin
        state_n     = state;
        cycle_n     = cycle_count;
        empty_n     = empty_cnt;
        halt_n      = halt_reason;
        inst_zero_n = inst_zero;
`ifdef REG_DUMP_EN
        dump_idx_n   = dump_idx;
        dump_valid_n = dump_valid;
        dump_index_n = dump_index;
        dump_value_n = dump_value;
`endif
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = PH_PC;
                    cycle_n = 16'd0;
                    empty_n = 4'd0;
                    halt_n  = HALT_NONE;
                end
            end
            PH_PC:   if (tmr_last) state_n = PH_INST;
            PH_INST: if (tmr_last) state_n = PH_DATA;
            PH_DATA: if (tmr_last) state_n = PH_REG;
            PH_REG: begin
                if (tmr_last) begin
                    inst_zero_n = (instruction == 32'd0);
                    state_n     = EVAL;
                end
            end
            EVAL: begin
                cycle_n = cycle_count + 16'd1;
                empty_n = inst_zero ? (empty_cnt + 4'd1) : 4'd0;
                // Empty-limit is tested first so it wins a tie with the cycle limit.
                if (empty_n == EMPTY_LIMIT[3:0]) begin
                    halt_n = HALT_EMPTY;
                end else if (cycle_n == NUM_CYCLES[15:0]) begin
                    halt_n = HALT_CYCLES;
                end
                state_n = (halt_n != HALT_NONE) ? HALT_DEST : PH_PC;
            end
`ifdef REG_DUMP_EN
            DUMP: begin
                if (!dump_valid) begin
                    // dump_addr already shows dump_idx, so dump_data is this register's contents.
                    dump_valid_n = 1'b1;
                    dump_index_n = dump_idx;
                    dump_value_n = dump_data;
                end else if (dump_ready) begin
                    dump_valid_n = 1'b0;
                    if (dump_idx == 5'(NREGS - 1)) begin
                        dump_idx_n = 5'd0;
                        state_n    = DONE;
                    end else begin
                        dump_idx_n = dump_idx + 5'd1;
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase

        // Reload the phase timer on every state change with the length of the phase being entered.
        tmr_load = (state_n != state);
        case (state_n)
            PH_PC:   tmr_val = 8'(T_PC - 1);
            PH_INST: tmr_val = 8'(T_INST - 1);
            PH_DATA: tmr_val = 8'(T_DATA - 1);
            PH_REG:  tmr_val = 8'(T_REG - 1);
            default: tmr_val = 8'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cycle_count <= 16'd0;
            empty_cnt   <= 4'd0;
            halt_reason <= HALT_NONE;
            inst_zero   <= 1'b0;
            pc_clock    <= 1'b0;
            inst_clock  <= 1'b0;
            data_clock  <= 1'b0;
            muu_clock   <= 1'b0;
            reg_clock   <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            cycle_count <= cycle_n;
            empty_cnt   <= empty_n;
            halt_reason <= halt_n;
            inst_zero   <= inst_zero_n;
            // Strobes decode the next state so they line up with the state register and come straight from flops.
            pc_clock    <= (state_n == PH_PC);
            inst_clock  <= (state_n == PH_INST);
            data_clock  <= (state_n == PH_DATA);
            muu_clock   <= (state_n == PH_DATA);
            reg_clock   <= (state_n == PH_REG);
            running     <= (state_n != IDLE) && (state_n != DUMP) && (state_n != DONE);
            done        <= (state_n == DONE);
        end
    end

`ifdef REG_DUMP_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            dump_idx   <= 5'd0;
            dump_valid <= 1'b0;
            dump_index <= 5'd0;
            dump_value <= 32'd0;
        end else begin
            dump_idx   <= dump_idx_n;
            dump_valid <= dump_valid_n;
            dump_index <= dump_index_n;
            dump_value <= dump_value_n;
        end
    end

    assign dump_addr = dump_idx;
`else
    logic unused_dump;
    assign unused_dump = ^{dump_data, dump_ready};

    assign dump_addr  = 5'd0;
    assign dump_valid = 1'b0;
    assign dump_index = 5'd0;
    assign dump_value = 32'd0;
`endif

endmodule

// File: tb/tb_uniciclo_phase_sequencer.sv
// Directed self-checking bench for uniciclo_phase_sequencer (three instances with different cycle limits).
// Latency: n/a. Backpressure: dump_ready is stalled for 3 ticks at index 7 when the dump is built.
module tb_uniciclo_phase_sequencer;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Instance A: default parameters, 5 nonzero words then zeros.
    logic        start_a, dump_ready_a;
    logic [31:0] instr_a, dump_data_a;
    logic        pc_a, inst_a, data_a, muu_a, reg_a, running_a, done_a, dump_valid_a;
    logic [1:0]  halt_a;
    logic [15:0] cc_a;
    logic [4:0]  dump_addr_a, dump_index_a;
    logic [31:0] dump_value_a;
    logic [7:0]  npc_a;
    logic        pc_a_q;

    // Instance B: NUM_CYCLES=4, every word nonzero.
    logic        start_b;
    logic        pc_b, inst_b, data_b, muu_b, reg_b, running_b, done_b, dump_valid_b;
    logic [1:0]  halt_b;
    logic [15:0] cc_b;
    logic [4:0]  dump_addr_b, dump_index_b;
    logic [31:0] dump_value_b;

    // Instance C: NUM_CYCLES=3, every word zero (empty and cycle limits meet on EVAL 3).
    logic        start_c;
    logic        pc_c, inst_c, data_c, muu_c, reg_c, running_c, done_c, dump_valid_c;
    logic [1:0]  halt_c;
    logic [15:0] cc_c;
    logic [4:0]  dump_addr_c, dump_index_c;
    logic [31:0] dump_value_c;

    wire [67:0] outs_a = {pc_a, inst_a, data_a, muu_a, reg_a, running_a, done_a, halt_a, cc_a,
                          dump_addr_a, dump_valid_a, dump_index_a, dump_value_a};
    wire [67:0] outs_b = {pc_b, inst_b, data_b, muu_b, reg_b, running_b, done_b, halt_b, cc_b,
                          dump_addr_b, dump_valid_b, dump_index_b, dump_value_b};

    // Instruction stream for A follows the number of pc_clock pulses seen so far.
    always @(posedge clock) begin
        if (reset) begin
            npc_a  <= 8'd0;
            pc_a_q <= 1'b0;
        end else begin
            if (pc_a && !pc_a_q) npc_a <= npc_a + 8'd1;
            pc_a_q <= pc_a;
        end
    end
    assign instr_a     = (npc_a >= 8'd1 && npc_a <= 8'd5) ? {24'h200000, npc_a} : 32'd0;
    assign dump_data_a = {27'd0, dump_addr_a} * 32'h11;

    uniciclo_phase_sequencer dut_a (
        .clock(clock), .reset(reset), .start(start_a), .instruction(instr_a),
        .pc_clock(pc_a), .inst_clock(inst_a), .data_clock(data_a), .muu_clock(muu_a), .reg_clock(reg_a),
        .running(running_a), .done(done_a), .halt_reason(halt_a), .cycle_count(cc_a),
        .dump_addr(dump_addr_a), .dump_data(dump_data_a), .dump_valid(dump_valid_a),
        .dump_ready(dump_ready_a), .dump_index(dump_index_a), .dump_value(dump_value_a)
    );

    uniciclo_phase_sequencer #(.NUM_CYCLES(4)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .instruction(32'hDEAD_BEEF),
        .pc_clock(pc_b), .inst_clock(inst_b), .data_clock(data_b), .muu_clock(muu_b), .reg_clock(reg_b),
        .running(running_b), .done(done_b), .halt_reason(halt_b), .cycle_count(cc_b),
        .dump_addr(dump_addr_b), .dump_data(32'd0), .dump_valid(dump_valid_b),
        .dump_ready(1'b1), .dump_index(dump_index_b), .dump_value(dump_value_b)
    );

    uniciclo_phase_sequencer #(.NUM_CYCLES(3)) dut_c (
        .clock(clock), .reset(reset), .start(start_c), .instruction(32'd0),
        .pc_clock(pc_c), .inst_clock(inst_c), .data_clock(data_c), .muu_clock(muu_c), .reg_clock(reg_c),
        .running(running_c), .done(done_c), .halt_reason(halt_c), .cycle_count(cc_c),
        .dump_addr(dump_addr_c), .dump_data(32'd0), .dump_valid(dump_valid_c),
        .dump_ready(1'b1), .dump_index(dump_index_c), .dump_value(dump_value_c)
    );

    int checks   = 0;
    int failures = 0;
    int pcs_b;
    logic pc_b_prev;
    logic [4:0] exp_s;
    int phase_pos;
    int dump_e, dump_hold, dump_budget;
    logic dump_acc;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        dump_ready_a = 1'b1;
        repeat (3) tick();
        chk("reset_outs_a", outs_a, 68'd0);
        chk("reset_outs_b", outs_b, 68'd0);
        reset = 1'b0;
        tick();
        chk("idle_outs_a", outs_a, 68'd0);

        start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        pcs_b = 0;
        pc_b_prev = 1'b0;

        // k is ticks since the start edge; each 13-tick period is pc(1) inst(5) data/muu(5) reg(1) eval(1).
        for (int k = 0; k <= 104; k++) begin
            phase_pos = k % 13;
            if (k >= 104)             exp_s = 5'b00000;
            else if (phase_pos == 0)  exp_s = 5'b10000;
            else if (phase_pos <= 5)  exp_s = 5'b01000;
            else if (phase_pos <= 10) exp_s = 5'b00110;
            else if (phase_pos == 11) exp_s = 5'b00001;
            else                      exp_s = 5'b00000;
            chk("strobes_running_a", {pc_a, inst_a, data_a, muu_a, reg_a, running_a}, {exp_s, (k < 104)});

            if (pc_b && !pc_b_prev) pcs_b++;
            pc_b_prev = pc_b;

            if (k == 0)   chk("count_at_start_a", {halt_a, cc_a}, {2'd0, 16'd0});
            if (k == 13)  chk("count_after_first_a", cc_a, 16'd1);
            if (k == 103) chk("eval8_not_yet_halted_a", {halt_a, cc_a}, {2'd0, 16'd7});
            start_c = (k == 20);
            if (k == 21)  chk("start_ignored_c", {data_c, running_c, cc_c}, {1'b1, 1'b1, 16'd1});
            if (k == 39) begin
                chk("tie_empty_wins_c", {halt_c, cc_c, running_c}, {2'd1, 16'd3, 1'b0});
`ifndef REG_DUMP_EN
                chk("done_c", done_c, 1'b1);
`endif
            end
            if (k == 52) begin
                chk("cycle_limit_b", {halt_b, cc_b, running_b}, {2'd2, 16'd4, 1'b0});
`ifndef REG_DUMP_EN
                chk("done_b", done_b, 1'b1);
`endif
            end
            if (k < 104) tick();
        end
        chk("pc_pulses_b", pcs_b, 4);
        chk("empty_limit_a", {halt_a, cc_a}, {2'd1, 16'd8});

`ifdef REG_DUMP_EN
        chk("dump_entry_a", {done_a, dump_valid_a}, 2'b00);
        dump_e = 0;
        dump_hold = 0;
        dump_budget = 0;
        while (dump_e < 32 && dump_budget < 300) begin
            chk("dump_addr_a", dump_addr_a, dump_e);
            dump_acc = 1'b0;
            if (dump_valid_a) begin
                chk("dump_index_a", dump_index_a, dump_e);
                chk("dump_value_a", dump_value_a, dump_e * 17);
                if (dump_e == 7 && dump_hold < 3) begin
                    dump_ready_a = 1'b0;
                    dump_hold++;
                end else begin
                    dump_ready_a = 1'b1;
                    dump_acc = 1'b1;
                end
            end else begin
                dump_ready_a = 1'b1;
            end
            tick();
            dump_budget++;
            if (dump_acc) dump_e++;
        end
        dump_ready_a = 1'b1;
        chk("dump_words_a", dump_e, 32);
        chk("dump_stall_ticks_a", dump_hold, 3);
        chk("dump_then_done_a", {done_a, dump_valid_a, halt_a, cc_a}, {1'b1, 1'b0, 2'd1, 16'd8});
`else
        chk("done_no_dump_a", {done_a, dump_addr_a, dump_valid_a, dump_index_a, dump_value_a}, {1'b1, 43'd0});
        tick();
        chk("done_held_a", {done_a, halt_a, cc_a}, {1'b1, 2'd1, 16'd8});
`endif

        // Restart from DONE clears counters, then reset in PH_DATA of instruction 2.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("restart_clear_a", {pc_a, done_a, halt_a, cc_a}, {1'b1, 1'b0, 2'd0, 16'd0});
        repeat (20) tick();
        chk("mid_data_inst2_a", {data_a, muu_a, cc_a}, {1'b1, 1'b1, 16'd1});
        reset = 1'b1;
        tick();
        chk("reset_mid_run_a", outs_a, 68'd0);
        chk("reset_from_done_b", outs_b, 68'd0);
        reset = 1'b0;
        tick();
        tick();
        chk("idle_after_reset_a", outs_a, 68'd0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("rerun_start_a", {pc_a, running_a, cc_a}, {1'b1, 1'b1, 16'd0});
        repeat (13) tick();
        chk("rerun_first_count_a", {pc_a, cc_a}, {1'b1, 16'd1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
